// File: rtl/mmio_pcm_capture.sv
// MMIO-controlled PCM capture engine: decimates a sample stream into a FWFT FIFO
// under a start/abort/clear command register, with status, count and level readback.
module mmio_pcm_capture #(
  parameter int unsigned AW = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [4:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic [15:0] pcm_in,
  input  logic        pcm_valid
);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e      state_q;
  logic [15:0] len_q, cnt_q;
  logic [7:0]  dec_q, dec_cnt_q;
  logic        ovf_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [15:0] mem_q [2**AW];

  logic [2:0]  a;
  logic        ctrl_we, start, abort, clear;
  logic        empty, full, pop, take, accept, push, ovf_set;
  logic [AW:0] level;

  assign a       = addr[2:0];
  assign ctrl_we = cs && write && (a == 3'd0);
  assign start   = ctrl_we && write_data[0];
  assign abort   = ctrl_we && write_data[1];
  assign clear   = ctrl_we && write_data[2];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign pop = cs && read && (a == 3'd3) && !empty && !clear;

  // A valid sample only advances decimation while the capture is still collecting.
  assign take    = (state_q == StCapture) && pcm_valid && (cnt_q < len_q) && !start && !abort;
  assign accept  = take && (dec_cnt_q == dec_q);
  assign push    = accept && (!full || pop) && !clear;
  assign ovf_set = accept && full && !pop && !clear;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      dec_cnt_q <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (cs && write && (a == 3'd1)) len_q <= write_data[15:0];
      if (cs && write && (a == 3'd2)) dec_q <= write_data[7:0];

      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if (start || clear) ovf_q <= 1'b0;
      else if (ovf_set)   ovf_q <= 1'b1;

      if (abort) begin
        state_q <= StIdle;
      end else if (start) begin
        state_q   <= (len_q == 16'd0) ? StDone : StCapture;
        cnt_q     <= '0;
        dec_cnt_q <= '0;
      end else begin
        if (take) dec_cnt_q <= accept ? 8'd0 : dec_cnt_q + 8'd1;
        if (push) cnt_q <= cnt_q + 16'd1;
        if (state_q == StCapture && cnt_q >= len_q) state_q <= StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= pcm_in;
  end

  always_comb begin
    read_data = '0;
    unique case (a)
      3'd0: read_data = {27'b0, ovf_q, full, empty, state_q == StDone, state_q == StCapture};
      3'd1: read_data = {16'b0, cnt_q};
      3'd2: read_data = {24'b0, dec_q};
      3'd3: read_data = empty ? 32'd0 : {16'b0, mem_q[rd_ptr_q[AW-1:0]]};
      3'd4: read_data = {{(31 - AW){1'b0}}, level};
      default: read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_pcm_capture.sv
// Directed bench for mmio_pcm_capture with a queue scoreboard mirroring the FIFO contents.
module tb_mmio_pcm_capture;

  logic        clk = 1'b0;
  logic        reset_n, cs, write, read, pcm_valid;
  logic [4:0]  addr;
  logic [31:0] write_data, read_data;
  logic [15:0] pcm_in;

  int checks = 0;
  int failures = 0;

  logic [15:0] sb [$];
  logic [15:0] m_len, m_cnt;
  logic [7:0]  m_dec, m_dec_cnt;
  logic        m_cap;

  mmio_pcm_capture #(.AW(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .write      (write),
    .read       (read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .pcm_in     (pcm_in),
    .pcm_valid  (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge, so each strobe spans exactly one rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {2'b0, a}; write_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
    if (a == 3'd1) m_len = d[15:0];
    if (a == 3'd2) m_dec = d[7:0];
    if (a == 3'd0 && d[2]) sb.delete();
    if (a == 3'd0 && d[1]) m_cap = 1'b0;
    else if (a == 3'd0 && d[0]) begin
      m_cnt = '0; m_dec_cnt = '0; m_cap = (m_len != 16'd0);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic do_pop, output logic [31:0] d);
    cs = 1'b1; read = do_pop; addr = {2'b0, a};
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  function automatic void model_sample(input logic [15:0] v, input logic popped);
    if (m_cap && m_cnt < m_len) begin
      if (m_dec_cnt == m_dec) begin
        m_dec_cnt = '0;
        if (sb.size() < 256 || popped) begin
          sb.push_back(v);
          m_cnt++;
        end
      end else begin
        m_dec_cnt++;
      end
    end
  endfunction

  task automatic sample(input logic [15:0] v);
    pcm_in = v; pcm_valid = 1'b1;
    model_sample(v, 1'b0);
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] d;
    logic [15:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 16'd0;
    rd(3'd3, 1'b1, d);
    chk(tag, d, {16'b0, e});
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, 1'b0, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] e;
    int n;
    reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0;
    write_data = '0; pcm_in = '0; pcm_valid = 1'b0;
    m_len = '0; m_cnt = '0; m_dec = '0; m_dec_cnt = '0; m_cap = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    reg_chk("reset_status", 3'd0, 32'h4);
    reg_chk("reset_level", 3'd4, 32'd0);
    reg_chk("reset_cnt", 3'd1, 32'd0);
    reg_chk("reset_dec", 3'd2, 32'd0);

    // len=4, dec=0, six samples: only the first four land
    wr(3'd2, 32'd0); wr(3'd1, 32'd4); wr(3'd0, 32'h1);
    for (int i = 1; i <= 6; i++) sample(16'(i));
    reg_chk("s1_status", 3'd0, 32'h2);
    reg_chk("s1_level", 3'd4, 32'(sb.size()));
    reg_chk("s1_cnt", 3'd1, 32'd4);
    n = sb.size();
    for (int i = 0; i < n; i++) pop_chk("s1_pop");
    reg_chk("s1_empty_status", 3'd0, 32'h6);
    pop_chk("s1_pop_empty");
    reg_chk("s1_level_after", 3'd4, 32'd0);
    reg_chk("unmapped_addr5", 3'd5, 32'd0);

    // len=3, dec=2 keeps every third sample
    wr(3'd2, 32'd2); wr(3'd1, 32'd3); wr(3'd0, 32'h1);
    for (int i = 10; i <= 18; i++) sample(16'(i));
    @(negedge clk);
    reg_chk("s2_dec", 3'd2, 32'd2);
    reg_chk("s2_cnt", 3'd1, 32'd3);
    reg_chk("s2_level", 3'd4, 32'd3);
    reg_chk("s2_status", 3'd0, 32'h2);
    n = sb.size();
    for (int i = 0; i < n; i++) pop_chk("s2_pop");

    // len=300 into a 256-deep FIFO with no pops: overflow
    wr(3'd2, 32'd0); wr(3'd1, 32'd300); wr(3'd0, 32'h1);
    for (int i = 1; i <= 300; i++) sample(16'(i));
    reg_chk("s3_level", 3'd4, 32'd256);
    reg_chk("s3_status", 3'd0, 32'h19);
    reg_chk("s3_cnt", 3'd1, 32'd256);

    // Full FIFO: pop and push in the same cycle
    pcm_in = 16'hABCD; pcm_valid = 1'b1; cs = 1'b1; read = 1'b1; addr = 5'd3;
    e = sb.pop_front();
    model_sample(16'hABCD, 1'b1);
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0; pcm_valid = 1'b0;
    chk("s4_head", d, {16'b0, e});
    reg_chk("s4_level", 3'd4, 32'd256);
    reg_chk("s4_cnt", 3'd1, 32'd257);
    n = sb.size();
    for (int i = 0; i < n; i++) pop_chk("s4_pop");
    reg_chk("s4_drained_status", 3'd0, 32'h15);

    // Abort after 2 of 5 samples, then start with len=0
    wr(3'd0, 32'h4);
    reg_chk("clear_ovf_status", 3'd0, 32'h5);
    wr(3'd1, 32'd5); wr(3'd0, 32'h1);
    sample(16'h0111); sample(16'h0222);
    wr(3'd0, 32'h3);
    reg_chk("s5_status", 3'd0, 32'h0);
    reg_chk("s5_level", 3'd4, 32'd2);
    sample(16'h0333);
    reg_chk("s5_idle_ignore", 3'd4, 32'(sb.size()));
    wr(3'd1, 32'd0); wr(3'd0, 32'h1);
    reg_chk("s5_len0_status", 3'd0, 32'h2);
    reg_chk("s5_len0_level", 3'd4, 32'd2);
    pop_chk("s5_pop");

    // Reset mid-capture with 10 buffered samples
    wr(3'd0, 32'h4); wr(3'd1, 32'd20); wr(3'd0, 32'h1);
    for (int i = 0; i < 10; i++) sample(16'(16'h0500 + i));
    reg_chk("s6_level", 3'd4, 32'd10);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    reg_chk("s6_status", 3'd0, 32'h4);
    reg_chk("s6_level_after", 3'd4, 32'd0);
    reg_chk("s6_len_after", 3'd1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
